// File: rtl/dram_arbiter_pkg.sv
// Shared definitions for the multi-core data-RAM front end: FSM state encodings
// and a width helper used to size the round-robin pointer.
package dram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_MEM  = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  // Bits needed to index n items, never less than one.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/dram_arbiter_bank.sv
// Single-port synchronous data RAM with one cycle of read latency.
// Read-first: q returns the word stored before a same-edge write.
module dram_bank #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // NOTE: the array has no reset so it maps onto a RAM macro; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= d;
    q <= mem_q[addr];
  end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin front end that serialises per-core requests onto one RAM bank,
// one ARB -> MEM -> DONE slot per access, with optional same-address read merging.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int N_CORES     = 2,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int MERGE_READS = 1
) (
  input  logic                        MAIN_CLOCK,
  input  logic                        RESET_N,
  input  logic [N_CORES-1:0]          CORE_REQ,
  input  logic [N_CORES-1:0]          CORE_WRITE_EN,
  input  logic [N_CORES*ADDR_W-1:0]   CORE_ADDRESS,
  input  logic [N_CORES*DATA_W-1:0]   CORE_DATA,
  output logic [N_CORES-1:0]          CORE_ACK,
  output logic [DATA_W-1:0]           DATA_FROM_RAM,
  output logic [$clog2(N_CORES)-1:0]  GRANT_ID,
  output logic                        BUSY
);

  localparam int PTR_W = clog2(N_CORES);

  typedef struct packed {
    logic             valid;
    logic [PTR_W-1:0] idx;
  } win_t;

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   grant_q, grant_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               we_q, we_d;
  logic [N_CORES-1:0] merge_q, merge_d;

  logic [ADDR_W-1:0]  core_addr [N_CORES];
  logic [DATA_W-1:0]  core_data [N_CORES];
  logic [N_CORES-1:0] eligible;
  logic [N_CORES-1:0] grant_mask;
  logic [DATA_W-1:0]  ram_q;
  logic [DATA_W-1:0]  done_word;
  logic               ram_we;
  win_t               win;

  // Explicit wrap keeps the pointer legal for non-power-of-two core counts.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N_CORES-1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic win_t pick_winner(input logic [N_CORES-1:0] elig,
                                       input logic [PTR_W-1:0]   ptr);
    win_t             w;
    logic [PTR_W-1:0] idx;
    w   = '0;
    idx = ptr;
    for (int k = 0; k < N_CORES; k++) begin
      if (elig[idx] && !w.valid) begin
        w.valid = 1'b1;
        w.idx   = idx;
      end
      idx = ptr_inc(idx);
    end
    return w;
  endfunction

  always_comb begin
    for (int i = 0; i < N_CORES; i++) begin
      core_addr[i]  = CORE_ADDRESS[i*ADDR_W +: ADDR_W];
      core_data[i]  = CORE_DATA[i*DATA_W +: DATA_W];
      grant_mask[i] = (grant_q == PTR_W'(i));
    end
  end

  // A core still seeing its ACK must not be picked again on a stale REQ.
  assign eligible  = CORE_REQ & ~CORE_ACK;
  assign win       = pick_winner(eligible, rr_ptr_q);
  assign done_word = we_q ? wdata_q : ram_q;
  assign ram_we    = (state_q == ST_MEM) && we_q;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ARB:  if (win.valid) state_d = ST_MEM;
      ST_MEM:  state_d = ST_DONE;
      ST_DONE: state_d = ST_ARB;
      default: state_d = ST_ARB;
    endcase
  end

  // Slot capture: everything the access needs is frozen in ARB.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    if (state_q == ST_ARB && win.valid) begin
      grant_d  = win.idx;
      addr_d   = core_addr[win.idx];
      wdata_d  = core_data[win.idx];
      we_d     = CORE_WRITE_EN[win.idx];
      rr_ptr_d = ptr_inc(win.idx);
      merge_d  = '0;
      if (MERGE_READS != 0 && !CORE_WRITE_EN[win.idx]) begin
        for (int i = 0; i < N_CORES; i++) begin
          merge_d[i] = eligible[i] && !CORE_WRITE_EN[i] &&
                       (core_addr[i] == core_addr[win.idx]) &&
                       (win.idx != PTR_W'(i));
        end
      end
    end
    if (state_q == ST_DONE) rdata_d = done_word;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge MAIN_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_ARB;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      merge_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      we_q     <= we_d;
      merge_q  <= merge_d;
    end
  end

  // Outputs decode from the state register, so reset clears ACK without waiting for an edge.
  always_comb begin
    BUSY          = (state_q != ST_ARB);
    CORE_ACK      = (state_q == ST_DONE) ? (grant_mask | merge_q) : '0;
    DATA_FROM_RAM = (state_q == ST_DONE) ? done_word : rdata_q;
    GRANT_ID      = grant_q;
  end

  dram_bank #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk  (MAIN_CLOCK),
    .we   (ram_we),
    .addr (addr_q),
    .d    (wdata_q),
    .q    (ram_q)
  );

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: a 4-core merging instance and a 2-core
// instance with merging disabled share clock and reset.
module tb_dram_arbiter;

  logic        clk;
  logic        rst_n;

  logic [3:0]  req, we, ack;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [15:0] rdata;
  logic [1:0]  grant;
  logic        busy;

  logic [1:0]  req2, we2, ack2;
  logic [15:0] addr2;
  logic [31:0] wdata2;
  logic [15:0] rdata2;
  logic [0:0]  grant2;
  logic        busy2;

  int total = 0;
  int bad   = 0;

  dram_arbiter #(.N_CORES(4), .DATA_W(16), .ADDR_W(8), .MERGE_READS(1)) u_dut (
    .MAIN_CLOCK    (clk),
    .RESET_N       (rst_n),
    .CORE_REQ      (req),
    .CORE_WRITE_EN (we),
    .CORE_ADDRESS  (addr),
    .CORE_DATA     (wdata),
    .CORE_ACK      (ack),
    .DATA_FROM_RAM (rdata),
    .GRANT_ID      (grant),
    .BUSY          (busy)
  );

  dram_arbiter #(.N_CORES(2), .DATA_W(16), .ADDR_W(8), .MERGE_READS(0)) u_nomerge (
    .MAIN_CLOCK    (clk),
    .RESET_N       (rst_n),
    .CORE_REQ      (req2),
    .CORE_WRITE_EN (we2),
    .CORE_ADDRESS  (addr2),
    .CORE_DATA     (wdata2),
    .CORE_ACK      (ack2),
    .DATA_FROM_RAM (rdata2),
    .GRANT_ID      (grant2),
    .BUSY          (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_core(input int i, input logic r, input logic w,
                          input logic [7:0] a, input logic [15:0] d);
    req[i]           = r;
    we[i]            = w;
    addr[i*8 +: 8]   = a;
    wdata[i*16 +: 16] = d;
  endtask

  task automatic set_core2(input int i, input logic r, input logic w,
                           input logic [7:0] a, input logic [15:0] d);
    req2[i]            = r;
    we2[i]             = w;
    addr2[i*8 +: 8]    = a;
    wdata2[i*16 +: 16] = d;
  endtask

  // Waits up to 12 falling edges for any ACK on the 4-core instance; n=0 means none came.
  task automatic wait_ack(output logic [3:0] a, output logic [15:0] d,
                          output logic [1:0] g, output int n);
    a = '0; d = '0; g = '0; n = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ack !== 4'b0000) begin
        a = ack; d = rdata; g = grant; n = i;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    req2  = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] a; logic [15:0] d; logic [1:0] g; int n;
    for (int i = 0; i < 4; i++) set_core(i, 1'b1, 1'b0, 8'(i), 16'h0000);
    repeat (2) @(negedge clk);
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b want=0000", ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (grant !== 2'd0) begin bad++; $display("FAIL reset_grant got=%0d want=0", grant); end
    total++; if (rdata !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h want=0000", rdata); end
    rst_n = 1'b1;
    wait_ack(a, d, g, n);
    total++; if (a !== 4'b0001) begin bad++; $display("FAIL reset_first_ack got=%b want=0001", a); end
    total++; if (n !== 2) begin bad++; $display("FAIL reset_first_latency got=%0d want=2", n); end
    req = '0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_write_read();
    logic [3:0] a; logic [15:0] d; logic [1:0] g; int n;
    apply_reset();
    set_core(0, 1'b1, 1'b1, 8'h12, 16'hBEEF);
    wait_ack(a, d, g, n);
    total++; if (a !== 4'b0001 || n !== 2) begin bad++; $display("FAIL wr_ack got=%b/%0d want=0001/2", a, n); end
    total++; if (d !== 16'hBEEF) begin bad++; $display("FAIL wr_data got=%h want=beef", d); end
    req[0] = 1'b0;
    @(negedge clk);
    set_core(0, 1'b1, 1'b0, 8'h12, 16'h0000);
    wait_ack(a, d, g, n);
    total++; if (a !== 4'b0001 || n !== 2) begin bad++; $display("FAIL rd_ack got=%b/%0d want=0001/2", a, n); end
    total++; if (d !== 16'hBEEF) begin bad++; $display("FAIL rd_data got=%h want=beef", d); end
    req[0] = 1'b0;
    @(negedge clk);
    total++; if (rdata !== 16'hBEEF || busy !== 1'b0) begin bad++; $display("FAIL rd_hold got=%h/%b want=beef/0", rdata, busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] a; logic [15:0] d; logic [1:0] g; int n;
    logic [3:0] exp_a;
    apply_reset();
    for (int i = 0; i < 4; i++) set_core(i, 1'b1, 1'b0, 8'(8'h20 + i), 16'h0000);
    for (int k = 0; k < 5; k++) begin
      exp_a = 4'(1 << (k % 4));
      wait_ack(a, d, g, n);
      total++; if (a !== exp_a) begin bad++; $display("FAIL rr_order[%0d] got=%b want=%b", k, a, exp_a); end
      total++; if (g !== 2'(k % 4)) begin bad++; $display("FAIL rr_grant[%0d] got=%0d want=%0d", k, g, k % 4); end
      total++; if (n !== ((k == 0) ? 2 : 3)) begin bad++; $display("FAIL rr_spacing[%0d] got=%0d want=%0d", k, n, (k == 0) ? 2 : 3); end
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_merge();
    logic [3:0] a; logic [15:0] d; logic [1:0] g; int n;
    logic [1:0] got2; logic [15:0] d2; int n2; logic extra;
    set_core(0, 1'b1, 1'b1, 8'h40, 16'h1234);
    set_core2(0, 1'b1, 1'b1, 8'h40, 16'h1234);
    wait_ack(a, d, g, n);
    total++; if (a !== 4'b0001 || ack2 !== 2'b01) begin bad++; $display("FAIL preload_ack got=%b/%b want=0001/01", a, ack2); end
    req = '0; req2 = '0;
    @(negedge clk);
    set_core(0, 1'b1, 1'b0, 8'h40, 16'h0000);
    set_core(1, 1'b1, 1'b0, 8'h40, 16'h0000);
    set_core2(0, 1'b1, 1'b0, 8'h40, 16'h0000);
    set_core2(1, 1'b1, 1'b0, 8'h40, 16'h0000);
    wait_ack(a, d, g, n);
    total++; if (a !== 4'b0011 || n !== 2) begin bad++; $display("FAIL merge_ack got=%b/%0d want=0011/2", a, n); end
    total++; if (d !== 16'h1234) begin bad++; $display("FAIL merge_data got=%h want=1234", d); end
    total++; if (g !== 2'd1) begin bad++; $display("FAIL merge_grant got=%0d want=1", g); end
    total++; if (ack2 !== 2'b10 || rdata2 !== 16'h1234) begin bad++; $display("FAIL nomerge_first got=%b/%h want=10/1234", ack2, rdata2); end
    req = '0;
    req2[1] = 1'b0;
    got2 = '0; d2 = '0; n2 = 0; extra = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ack !== 4'b0000) extra = 1'b1;
      if (ack2 !== 2'b00) begin
        got2 = ack2; d2 = rdata2; n2 = i;
        break;
      end
    end
    total++; if (got2 !== 2'b01 || n2 !== 3) begin bad++; $display("FAIL nomerge_second got=%b/%0d want=01/3", got2, n2); end
    total++; if (d2 !== 16'h1234) begin bad++; $display("FAIL nomerge_data got=%h want=1234", d2); end
    total++; if (extra !== 1'b0) begin bad++; $display("FAIL merge_no_extra_slot got=%b want=0", extra); end
    req2 = '0;
    @(negedge clk);
  endtask

  task automatic test_clash();
    logic [3:0] a; logic [15:0] d; logic [1:0] g; int n;
    apply_reset();
    set_core(0, 1'b1, 1'b0, 8'h40, 16'h0000);
    set_core(1, 1'b1, 1'b1, 8'h40, 16'h0007);
    wait_ack(a, d, g, n);
    total++; if (a !== 4'b0001 || d !== 16'h1234) begin bad++; $display("FAIL clash_read got=%b/%h want=0001/1234", a, d); end
    req[0] = 1'b0;
    wait_ack(a, d, g, n);
    total++; if (a !== 4'b0010 || n !== 3) begin bad++; $display("FAIL clash_write got=%b/%0d want=0010/3", a, n); end
    req[1] = 1'b0;
    @(negedge clk);
    set_core(0, 1'b1, 1'b0, 8'h40, 16'h0000);
    wait_ack(a, d, g, n);
    total++; if (a !== 4'b0001 || d !== 16'h0007) begin bad++; $display("FAIL clash_reread got=%b/%h want=0001/0007", a, d); end
    req[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [3:0] a; logic [15:0] d; logic [1:0] g; int n;
    logic seen;
    set_core(0, 1'b1, 1'b1, 8'h05, 16'h5555);
    wait_ack(a, d, g, n);
    total++; if (a !== 4'b0001) begin bad++; $display("FAIL mid_preload got=%b want=0001", a); end
    req[0] = 1'b0;
    apply_reset();
    set_core(1, 1'b1, 1'b1, 8'h05, 16'hAAAA);
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_in_mem got=%b want=1", busy); end
    rst_n = 1'b0;
    req = '0;
    #1;
    total++; if (ack !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL mid_mem_reset got=%b/%b want=0000/0", ack, busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ack !== 4'b0000) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_no_ack got=%b want=0", seen); end
    set_core(0, 1'b1, 1'b0, 8'h05, 16'h0000);
    wait_ack(a, d, g, n);
    total++; if (a !== 4'b0001 || d !== 16'h5555) begin bad++; $display("FAIL mid_prior_data got=%b/%h want=0001/5555", a, d); end
    rst_n = 1'b0;
    req = '0;
    #1;
    total++; if (ack !== 4'b0000 || rdata !== 16'h0000) begin bad++; $display("FAIL done_reset got=%b/%h want=0000/0000", ack, rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    req2 = '0; we2 = '0; addr2 = '0; wdata2 = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_merge();
    test_clash();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
